deco_pipe: RTL and testbench

DECO_PIPE -- requirements
Module: deco_pipe

---
 rtl/deco_pipe.sv | 154 +++++++++++++++
 tb/tb_deco_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/deco_pipe.sv
// Decode stage: instruction decode, register-file read and a single-entry output register.
// Optional macro DECO_PIPE_BYPASS_EN forwards a same-cycle write-back into the source operands.
module deco_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_instr,
  input  logic                       i_wb_en,
  input  logic [$clog2(NREGS)-1:0]   i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [4:0]                 o_opcode,
  output logic [$clog2(NREGS)-1:0]   o_rd,
  output logic [DATA_W-1:0]          o_rs_val,
  output logic [DATA_W-1:0]          o_rt_val,
  output logic [DATA_W-1:0]          o_imm,
  output logic                       o_illegal
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic                         r_out_valid;
  logic [4:0]                   r_opcode;
  logic [AW-1:0]                r_rd;
  logic [DATA_W-1:0]            r_rs_val;
  logic [DATA_W-1:0]            r_rt_val;
  logic [DATA_W-1:0]            r_imm;
  logic                         r_illegal;
  logic [AW-1:0]                r_src_a;
  logic [AW-1:0]                r_src_b;
  logic                         r_use_a;
  logic                         r_use_b;

  logic [4:0]        w_opcode;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_src_a;
  logic [AW-1:0]     w_src_b;
  logic              w_use_a;
  logic              w_use_b;
  logic [DATA_W-1:0] w_imm;
  logic              w_illegal;
  logic [DATA_W-1:0] w_a_val;
  logic [DATA_W-1:0] w_b_val;
  logic              w_wb_hit;
  logic              w_xfer;

  assign w_wb_hit   = i_wb_en && (i_wb_addr != '0);
  assign o_in_ready = !i_reset && (!r_out_valid || i_out_ready);
  assign w_xfer     = i_in_valid && o_in_ready;

  // Field extraction per opcode; source slot A/B map onto rs_val/rt_val.
  always_comb begin
    w_opcode  = i_instr[31:27];
    w_rd      = '0;
    w_src_a   = '0;
    w_src_b   = '0;
    w_use_a   = 1'b0;
    w_use_b   = 1'b0;
    w_imm     = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      5'd2, 5'd3, 5'd4, 5'd5: begin
        w_rd    = AW'(i_instr[26:18]);
        w_src_a = AW'(i_instr[17:9]);
        w_src_b = AW'(i_instr[8:0]);
        w_use_a = 1'b1;
        w_use_b = 1'b1;
      end
      5'd1, 5'd6: begin
        w_rd  = AW'(i_instr[26:20]);
        w_imm = DATA_W'(i_instr[19:0]);
      end
      5'd7: w_imm = DATA_W'(i_instr[6:0]);
      5'd8: begin
        w_src_a = AW'(i_instr[26:18]);
        w_src_b = AW'(i_instr[17:9]);
        w_use_a = 1'b1;
        w_use_b = 1'b1;
        w_imm   = DATA_W'(i_instr[8:0]);
      end
      5'd9: begin
        w_rd    = AW'(i_instr[26:18]);
        w_src_a = AW'(i_instr[26:18]);
        w_use_a = 1'b1;
        w_imm   = DATA_W'(i_instr[19:0]);
      end
      5'd10:   w_imm = DATA_W'(i_instr[17:0]);
      default: w_illegal = 1'b1;
    endcase
  end

  // Operand read; register 0 is never written so it always reads zero.
  always_comb begin
    w_a_val = w_use_a ? r_regs[w_src_a] : '0;
    w_b_val = w_use_b ? r_regs[w_src_b] : '0;
`ifdef DECO_PIPE_BYPASS_EN
    if (w_use_a && w_wb_hit && (i_wb_addr == w_src_a)) w_a_val = i_wb_data;
    if (w_use_b && w_wb_hit && (i_wb_addr == w_src_b)) w_b_val = i_wb_data;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_regs      <= '0;
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_use_a     <= 1'b0;
      r_use_b     <= 1'b0;
    end else begin
      if (w_wb_hit) r_regs[i_wb_addr] <= i_wb_data;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_opcode;
        r_rd        <= w_rd;
        r_rs_val    <= w_a_val;
        r_rt_val    <= w_b_val;
        r_imm       <= w_imm;
        r_illegal   <= w_illegal;
        r_src_a     <= w_src_a;
        r_src_b     <= w_src_b;
        r_use_a     <= w_use_a;
        r_use_b     <= w_use_b;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end else if (r_out_valid && w_wb_hit) begin
        // Held bundle tracks write-backs to its own source registers.
        if (r_use_a && (r_src_a == i_wb_addr)) r_rs_val <= i_wb_data;
        if (r_use_b && (r_src_b == i_wb_addr)) r_rt_val <= i_wb_data;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_opcode    = r_opcode;
  assign o_rd        = r_rd;
  assign o_rs_val    = r_rs_val;
  assign o_rt_val    = r_rt_val;
  assign o_imm       = r_imm;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_deco_pipe.sv
// Scoreboard bench for deco_pipe: driver pushes expected bundles, negedge monitor pops on acceptance.
module tb_deco_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned AW     = 5;

  typedef struct {
    logic [4:0]        op;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] imm;
    logic              ill;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        opcode;
  logic [AW-1:0]     rd;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm;
  logic              illegal;

  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  exp_t q[$];

  deco_pipe #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_instr(instr), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_opcode(opcode), .o_rd(rd),
    .o_rs_val(rs_val), .o_rt_val(rt_val), .o_imm(imm), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] f_rd,
                                     input logic [8:0] f_rs, input logic [8:0] f_rt);
    return {op, f_rd, f_rs, f_rt};
  endfunction

  function automatic exp_t mx(input logic [4:0] op, input logic [AW-1:0] e_rd,
                              input logic [31:0] e_rs, input logic [31:0] e_rt,
                              input logic [31:0] e_imm, input logic e_ill);
    exp_t e;
    e.op = op; e.rd = e_rd; e.rs = e_rs; e.rt = e_rt; e.imm = e_imm; e.ill = e_ill;
    return e;
  endfunction

  task automatic wb(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input exp_t e);
    in_valid = 1'b1;
    instr    = ins;
    #0;
    for (int n = 0; n < 20 && !in_ready; n++) tick();
    if (!in_ready) chk("issue_timeout", 64'(in_ready), 64'd1);
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: compare against the scoreboard whenever a bundle is accepted.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("b%0d_opcode", n_out), 64'(opcode), 64'(e.op));
        chk($sformatf("b%0d_rd", n_out), 64'(rd), 64'(e.rd));
        chk($sformatf("b%0d_rs_val", n_out), 64'(rs_val), 64'(e.rs));
        chk($sformatf("b%0d_rt_val", n_out), 64'(rt_val), 64'(e.rt));
        chk($sformatf("b%0d_imm", n_out), 64'(imm), 64'(e.imm));
        chk($sformatf("b%0d_illegal", n_out), 64'(illegal), 64'(e.ill));
      end
      n_out++;
    end
  end

  initial begin
    logic [31:0] bypass_exp;
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick();
    // Stimulus during reset must be ignored.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    in_valid = 1'b1; instr = mk(5'd2, 9'd1, 9'd2, 9'd3);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    wb_en = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_rs_val", 64'(rs_val), 64'd0);
    chk("post_reset_imm", 64'(imm), 64'd0);

    // Basic arith read.
    wb(5'd3, 32'h11);
    wb(5'd4, 32'h22);
    issue(mk(5'd2, 9'd5, 9'd3, 9'd4), mx(5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 1'b0));

    // Same-cycle write-back and accept.
`ifdef DECO_PIPE_BYPASS_EN
    bypass_exp = 32'h99;
`else
    bypass_exp = 32'h11;
`endif
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    issue(mk(5'd2, 9'd1, 9'd3, 9'd4), mx(5'd2, 5'd1, bypass_exp, 32'h22, 32'h0, 1'b0));
    wb_en = 1'b0;
    tick();

    // Hold for three cycles, write-back to rt during the hold.
    out_ready = 1'b0;
    issue(mk(5'd3, 9'd6, 9'd3, 9'd4), mx(5'd3, 5'd6, 32'h99, 32'h55, 32'h0, 1'b0));
    chk("hold0_in_ready", 64'(in_ready), 64'd0);
    chk("hold0_out_valid", 64'(out_valid), 64'd1);
    chk("hold0_rt_val", 64'(rt_val), 64'h22);
    tick();
    chk("hold1_in_ready", 64'(in_ready), 64'd0);
    chk("hold1_rd", 64'(rd), 64'd6);
    chk("hold1_rs_val", 64'(rs_val), 64'h99);
    wb(5'd4, 32'h55);
    chk("hold2_in_ready", 64'(in_ready), 64'd0);
    chk("hold2_rt_val", 64'(rt_val), 64'h55);
    chk("hold2_rs_val", 64'(rs_val), 64'h99);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // R0 write discarded; R5 write during reset ignored.
    wb(5'd0, 32'hFF);
    issue(mk(5'd2, 9'd7, 9'd0, 9'd5), mx(5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0));
    // Back-to-back decode of every format.
    issue(mk(5'd31, 9'h1FF, 9'h1FF, 9'h1FF), mx(5'd31, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1));
    issue({5'd1, 7'h15, 20'hABCDE}, mx(5'd1, 5'h15, 32'h0, 32'h0, 32'hABCDE, 1'b0));
    issue(mk(5'd8, 9'd3, 9'd4, 9'h1A5), mx(5'd8, 5'd0, 32'h99, 32'h55, 32'h1A5, 1'b0));
    issue({5'd9, 9'd4, 18'h21234}, mx(5'd9, 5'd4, 32'h55, 32'h0, 32'h21234, 1'b0));
    issue({5'd7, 27'h7FFFFFF}, mx(5'd7, 5'd0, 32'h0, 32'h0, 32'h7F, 1'b0));
    issue({5'd10, 27'h5ABCDEF}, mx(5'd10, 5'd0, 32'h0, 32'h0, 32'h3CDEF, 1'b0));
    issue({5'd6, 7'h7F, 20'h00001}, mx(5'd6, 5'h1F, 32'h0, 32'h0, 32'h1, 1'b0));
    issue(mk(5'd5, 9'h1E3, 9'h023, 9'h104), mx(5'd5, 5'd3, 32'h99, 32'h55, 32'h0, 1'b0));
    issue(mk(5'd0, 9'd1, 9'd2, 9'd3), mx(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1));
    tick();

    // Reset while a bundle is held discards it and clears the register file.
    out_ready = 1'b0;
    issue(mk(5'd2, 9'd5, 9'd3, 9'd4), mx(5'd2, 5'd5, 32'h99, 32'h55, 32'h0, 1'b0));
    chk("held_before_reset", 64'(out_valid), 64'd1);
    rst = 1'b1;
    q.delete();
    tick();
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_opcode", 64'(opcode), 64'd0);
    chk("rst_hold_rd", 64'(rd), 64'd0);
    chk("rst_hold_rs_val", 64'(rs_val), 64'd0);
    chk("rst_hold_rt_val", 64'(rt_val), 64'd0);
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    issue(mk(5'd2, 9'd1, 9'd3, 9'd4), mx(5'd2, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0));

    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
